// File: rtl/disp_pkg.sv
// Shared definitions for the display paging logic.
// Holds the page encoding and the display word width. The top module
// and any future display helpers import these.
package disp_pkg;

   // Width of the word the seven-segment scanner renders as hex
   localparam int DISP_W = 16;

   // Debug pages in front-panel order; a press steps to the next one
   typedef enum logic [1:0] {
      PAGE_PC  = 2'd0,
      PAGE_RS  = 2'd1,
      PAGE_RT  = 2'd2,
      PAGE_ALU = 2'd3
   } page_t;

   // Following page, wrapping from the last page back to the first
   function automatic page_t next_page(input page_t cur);
      return page_t'(cur + 2'd1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and
// debounced state, plus a single-cycle pulse on each accepted press.
// Written as a reusable block for any front-panel push button.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   btn_raw   in   raw asynchronous button, active-high
//   btn_state out  debounced button level
//   press_p   out  one-cycle pulse on an accepted 0->1 transition
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_state,
   output logic press_p
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          btn_s;
   logic [CW-1:0] count;
   logic          settle;

   // The synchronized level has disagreed with the accepted state long enough
   assign settle  = (btn_s != btn_state) && (count == LAST);

   // Decoded from the settle condition so the pulse lines up with the very
   // edge that updates btn_state; releases never pulse
   assign press_p = settle && btn_s;

   // Any agreement with the accepted state restarts the stability window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b0;
         btn_s     <= 1'b0;
         count     <= '0;
         btn_state <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         btn_s <= sync1;
         if (btn_s == btn_state) begin
            count <= '0;
         end else if (settle) begin
            btn_state <= btn_s;
            count     <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_page_ctrl.sv
// Feeder for the 4-digit seven-segment scanner on the CPU board.
// Generates the digit-scan clock, steps through four debug pages on a
// debounced front-panel button and registers the 16-bit display word.
//
// Ports:
//   CLK        in   board clock
//   RST        in   asynchronous active-high reset
//   btn_page   in   raw page button (bouncy, asynchronous)
//   pc         in   current PC
//   next_pc    in   next PC
//   rs_addr    in   rs register number
//   rs_data    in   rs register value
//   rt_addr    in   rt register number
//   rt_data    in   rt register value
//   alu_result in   ALU output
//   db_data    in   write-back data bus
//   CLK_190hz  out  scan clock, 2*DIV_HALF board cycles per period
//   disp_data  out  word to display
//   page       out  current page index
module disp_page_ctrl
   import disp_pkg::*;
#(
   parameter int DIV_HALF        = 263158,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              btn_page,
   input  logic [31:0]       pc,
   input  logic [31:0]       next_pc,
   input  logic [4:0]        rs_addr,
   input  logic [31:0]       rs_data,
   input  logic [4:0]        rt_addr,
   input  logic [31:0]       rt_data,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       db_data,
   output logic              CLK_190hz,
   output logic [DISP_W-1:0] disp_data,
   output logic [1:0]        page
);

   localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

   logic [DW-1:0] div_count;
   logic          btn_level;
   logic          press_p;
   page_t         page_q;

   // Only the low byte of each bus is shown; the rest is intentionally dropped
   logic unused_bits;
   assign unused_bits = ^{pc[31:8], next_pc[31:8], rs_data[31:8], rt_data[31:8],
                          alu_result[31:8], db_data[31:8], btn_level};

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk      (CLK),
      .rst      (RST),
      .btn_raw  (btn_page),
      .btn_state(btn_level),
      .press_p  (press_p)
   );

   // Scan clock toggles each time the counter completes a half period
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_count <= '0;
         CLK_190hz <= 1'b0;
      end else if (div_count == DIV_LAST) begin
         div_count <= '0;
         CLK_190hz <= ~CLK_190hz;
      end else begin
         div_count <= div_count + 1'b1;
      end
   end

   // Page advances once per accepted press, independent of the divider
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         page_q <= PAGE_PC;
      end else if (press_p) begin
         page_q <= next_page(page_q);
      end
   end

   assign page = page_q;

   // Display word resampled every cycle so live buses track with one cycle lag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         disp_data <= '0;
      end else begin
         case (page_q)
            PAGE_PC:  disp_data <= {pc[7:0], next_pc[7:0]};
            PAGE_RS:  disp_data <= {3'b000, rs_addr, rs_data[7:0]};
            PAGE_RT:  disp_data <= {3'b000, rt_addr, rt_data[7:0]};
            PAGE_ALU: disp_data <= {alu_result[7:0], db_data[7:0]};
            default:  disp_data <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Self-checking bench for disp_page_ctrl with a short divider and
// debounce window. Stimulus code pushes timed expectations into a
// scoreboard queue; a negedge monitor compares them when they fall due.
module tb_disp_page_ctrl;

   logic        CLK;
   logic        RST;
   logic        btn_page;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [4:0]  rs_addr;
   logic [31:0] rs_data;
   logic [4:0]  rt_addr;
   logic [31:0] rt_data;
   logic [31:0] alu_result;
   logic [31:0] db_data;
   logic        CLK_190hz;
   logic [15:0] disp_data;
   logic [1:0]  page;

   // Observation kinds held in the scoreboard
   localparam int K_PAGE = 0;
   localparam int K_DISP = 1;
   localparam int K_SCAN = 2;

   typedef struct {
      string       tag;
      int          due;
      int          kind;
      logic [15:0] value;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   relCyc = 0;
   int   curPage = 0;
   int   checks = 0;
   int   failures = 0;

   disp_page_ctrl #(
      .DIV_HALF       (4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .btn_page  (btn_page),
      .pc        (pc),
      .next_pc   (next_pc),
      .rs_addr   (rs_addr),
      .rs_data   (rs_data),
      .rt_addr   (rt_addr),
      .rt_data   (rt_data),
      .alu_result(alu_result),
      .db_data   (db_data),
      .CLK_190hz (CLK_190hz),
      .disp_data (disp_data),
      .page      (page)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle index: number of rising edges seen so far
   always @(posedge CLK) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Reference page map built from the bench's own input values
   function automatic logic [15:0] pageWord(input int p);
      case (p)
         0:       return {pc[7:0], next_pc[7:0]};
         1:       return {3'b000, rs_addr, rs_data[7:0]};
         2:       return {3'b000, rt_addr, rt_data[7:0]};
         default: return {alu_result[7:0], db_data[7:0]};
      endcase
   endfunction

   task automatic pushExpect(input string tag, input int kind, input int due,
                             input logic [15:0] value);
      exp_t e;
      e.tag   = tag;
      e.kind  = kind;
      e.due   = due;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic level);
      btn_page = level;
   endtask

   // Pop every expectation due this cycle; anything overdue is reported
   always @(negedge CLK) begin
      if (!RST) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
               if (sb[i].due < cyc) begin
                  checkOutput({sb[i].tag, "_missed"}, 32'd0, 32'd1);
               end else begin
                  case (sb[i].kind)
                     K_PAGE:  checkOutput(sb[i].tag, {30'd0, page}, {16'd0, sb[i].value});
                     K_DISP:  checkOutput(sb[i].tag, {16'd0, disp_data}, {16'd0, sb[i].value});
                     default: checkOutput(sb[i].tag, {31'd0, CLK_190hz}, {16'd0, sb[i].value});
                  endcase
               end
               sb.delete(i);
            end
         end
      end
   end

   // One full clean press (12 high, 12 low), expecting exactly one page step
   task automatic pressClean();
      int p;
      int nxt;
      p   = cyc;
      nxt = (curPage + 1) % 4;
      pushExpect("press_page_hold", K_PAGE, p + 9, 16'(curPage));
      pushExpect("press_page_step", K_PAGE, p + 10, 16'(nxt));
      pushExpect("press_disp", K_DISP, p + 11, pageWord(nxt));
      applyStimulus(1'b1);
      waitCycles(12);
      applyStimulus(1'b0);
      if (nxt == 3) begin
         waitCycles(2);
         db_data = 32'h00000011;
         pushExpect("live_db_disp", K_DISP, cyc + 1, {alu_result[7:0], 8'h11});
         waitCycles(10);
      end else begin
         waitCycles(12);
      end
      curPage = nxt;
   endtask

   initial begin
      RST        = 1'b1;
      btn_page   = 1'b0;
      pc         = 32'h00400004;
      next_pc    = 32'h00400008;
      rs_addr    = 5'h11;
      rs_data    = 32'h000000AB;
      rt_addr    = 5'h0A;
      rt_data    = 32'h000000CD;
      alu_result = 32'h12345678;
      db_data    = 32'h9ABCDEF0;

      #2;
      checkOutput("rst_page", {30'd0, page}, 32'd0);
      checkOutput("rst_scan", {31'd0, CLK_190hz}, 32'd0);
      checkOutput("rst_disp", {16'd0, disp_data}, 32'd0);

      // Divider phase and page-0 word after release
      waitCycles(2);
      RST = 1'b0;
      relCyc = cyc;
      pushExpect("init_page", K_PAGE, relCyc + 1, 16'd0);
      pushExpect("init_disp", K_DISP, relCyc + 1, 16'h0408);
      pushExpect("scan_e3", K_SCAN, relCyc + 3, 16'd0);
      pushExpect("scan_rise", K_SCAN, relCyc + 4, 16'd1);
      pushExpect("scan_e7", K_SCAN, relCyc + 7, 16'd1);
      pushExpect("scan_fall", K_SCAN, relCyc + 8, 16'd0);
      pushExpect("scan_rise2", K_SCAN, relCyc + 12, 16'd1);
      waitCycles(13);

      // Short bounce must be rejected
      begin
         int c;
         c = cyc;
         applyStimulus(1'b1);
         waitCycles(5);
         applyStimulus(1'b0);
         pushExpect("bounce_page", K_PAGE, c + 12, 16'd0);
         pushExpect("bounce_disp", K_DISP, c + 12, 16'h0408);
         waitCycles(14);
      end

      // Long hold: one step, none on release
      begin
         int c;
         c = cyc;
         pushExpect("hold_page_before", K_PAGE, c + 9, 16'd0);
         pushExpect("hold_disp_old", K_DISP, c + 10, 16'h0408);
         pushExpect("hold_page_step", K_PAGE, c + 10, 16'd1);
         pushExpect("hold_disp_rs", K_DISP, c + 11, 16'h11AB);
         applyStimulus(1'b1);
         waitCycles(30);
         applyStimulus(1'b0);
         pushExpect("release_no_step", K_PAGE, c + 45, 16'd1);
         waitCycles(16);
      end
      curPage = 1;

      pressClean();

      // Asynchronous reset mid-debounce with page 2 and divider count 3
      checkOutput("pre_rst_page", {30'd0, page}, 32'd2);
      applyStimulus(1'b1);
      waitCycles(4);
      for (int i = 0; i < 4 && ((cyc - relCyc) % 4 != 3); i++) waitCycles(1);
      #2 RST = 1'b1;
      #1;
      checkOutput("async_rst_page", {30'd0, page}, 32'd0);
      checkOutput("async_rst_scan", {31'd0, CLK_190hz}, 32'd0);
      checkOutput("async_rst_disp", {16'd0, disp_data}, 32'd0);
      waitCycles(2);
      RST = 1'b0;
      relCyc = cyc;
      curPage = 0;

      // Button still held: needs a full fresh window, then a release-bounce
      pushExpect("post_rst_disp", K_DISP, relCyc + 2, 16'h0408);
      pushExpect("post_rst_scan_e3", K_SCAN, relCyc + 3, 16'd0);
      pushExpect("post_rst_scan_rise", K_SCAN, relCyc + 4, 16'd1);
      pushExpect("post_rst_page_hold", K_PAGE, relCyc + 9, 16'd0);
      pushExpect("post_rst_page_step", K_PAGE, relCyc + 10, 16'd1);
      pushExpect("post_rst_disp_rs", K_DISP, relCyc + 11, 16'h11AB);
      waitCycles(15);
      applyStimulus(1'b0);
      waitCycles(3);
      applyStimulus(1'b1);
      pushExpect("rebounce_no_step", K_PAGE, relCyc + 30, 16'd1);
      waitCycles(12);
      applyStimulus(1'b0);
      pushExpect("rebounce_release", K_PAGE, relCyc + 42, 16'd1);
      waitCycles(14);
      curPage = 1;

      // Walk the remaining pages including the wrap
      repeat (4) pressClean();

      waitCycles(2);
      checkOutput("sb_pending", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
